path_mc: RTL and testbench
==========================

// Module: path_mc
// PURPOSE
//   Multi-channel request/grant datapath. NCH input channels, each buffered by its own
//   FIFO with an empty-FIFO bypass, merged onto one output port by a round-robin arbiter.
//   Adds to the single-channel path: a depth of any size, a programmable almost-full
//   stall, sticky per-channel overflow, and per-channel flush. Sits between producers
//   and a single granting consumer.
// PARAMETERS
//   DWIDTH  8  data width per channel
//   FDEPTH  5  entries per channel FIFO; any value >= 2, power of two not required
//   NCH     3  number of channels; >= 2
//   AFULL   4  stall threshold (entries); 1 <= AFULL <= FDEPTH
// PORTS
//   clk          in   1             single clock, rising edge
//   rst          in   1             synchronous, active-high reset
//   enable_i     in   1             global input enable; when low, valid_i is ignored
//   flush_i      in   NCH           per-channel FIFO flush
//   valid_i      in   NCH           per-channel input valid
//   data_i       in   NCH*DWIDTH    channel c occupies bits [c*DWIDTH +: DWIDTH]
//   gnt_i        in   1             consumer grant; pops the presented word
//   req_o        out  1             a word is presented on data_o
//   ch_o         out  CW            source channel of data_o; CW = clog2(NCH)
//   data_o       out  DWIDTH        presented word
//   stall_o      out  NCH           per-channel back-pressure
//   overflow_o   out  NCH           sticky: a push was dropped
//   underflow_o  out  1             gnt_i while req_o is low
// BEHAVIOUR
//   Reset: counts, pointers, rr_ptr and overflow_o are 0. Combinational outputs follow
//     their equations. data_o = 0 and ch_o = 0 whenever req_o = 0.
//   Pending: pend[c] = cnt[c] != 0 || (valid_i[c] && enable_i). req_o = |pend.
//   Arbitration: sel = first c with pend[c], scanning rr_ptr, rr_ptr+1, ... modulo NCH.
//     ch_o = sel.
//   data_o = cnt[sel] != 0 ? FIFO head of sel : data_i[sel] (bypass). Bypass latency is
//     0 cycles. A pushed word is visible at the FIFO head on the next cycle.
//   Pop when gnt_i && req_o:
//     - cnt[sel] != 0: the head is removed.
//     - cnt[sel] == 0: the bypass consumes valid_i[sel]; nothing is written.
//     - rr_ptr <= (sel+1) mod NCH on the next edge. rr_ptr holds without a grant.
//   Push on channel c: valid_i[c] && enable_i, and not consumed by bypass, and
//     (cnt[c] < FDEPTH, or a pop of c happens in the same cycle).
//     Push + pop on c in the same cycle leaves cnt unchanged.
//   Drop: valid_i[c] && enable_i && cnt[c] == FDEPTH, with no pop of c. Data is lost;
//     overflow_o[c] <= 1 on the next edge. It clears only on rst or flush_i[c].
//   Pointers wrap from FDEPTH-1 to 0. cnt width = clog2(FDEPTH+1). Never exceeds FDEPTH.
//   stall_o[c] = !enable_i || cnt[c] >= AFULL (combinational from registered cnt).
//   underflow_o = gnt_i && !req_o. Has no state effect.
//   flush_i[c]: next edge sets cnt, pointers and overflow_o[c] to 0.
//     - A same-cycle push to c is discarded.
//     - A same-cycle grant of c still delivers the presented word; rr_ptr still advances.
//     - Flush has priority over push, pop and drop.
//   rst mid-traffic: everything returns to the reset state on the next edge. In-flight
//     data is discarded.
// STRUCTURE
//   path_pkg:
//     - clog2 function
//     - CW/count-width localparam helpers
//     - rr_next(sel, NCH) function
//   Sub-module path_fifo (DWIDTH, FDEPTH):
//     - inputs: push, pop, flush
//     - outputs: head, cnt
//     - synchronous active-high rst
//     - NCH instances via generate
//   Arbiter, bypass mux, stall/overflow logic: inline in path_mc.
// TESTING (NCH=3, DWIDTH=8, FDEPTH=5, AFULL=4)
//   1. Bypass: all FIFOs empty, enable_i=1, valid_i=3'b010, data_i[1]=8'hA5, gnt_i=1
//      -> same cycle req_o=1, ch_o=1, data_o=A5; cnt[1] remains 0.
//   2. Round-robin: gnt_i=0; push 2 words each to ch0/1/2 (ch0: 10,11; ch1: 20,21;
//      ch2: 30,31); then gnt_i=1
//      -> data_o sequence 10, 20, 30, 11, 21, 31; then req_o=0.
//   3. Fill/stall/overflow: gnt_i=0, valid_i[0]=1, 6 cycles, data 1..6
//      -> stall_o[0]=1 after the 4th push; cnt[0]=5; overflow_o[0]=1 after the 6th.
//      Draining yields 1..5.
//   4. Full push+pop: ch0 full, valid_i[0]=1 with data 7, gnt_i=1, sel=0
//      -> head popped, 7 written, cnt[0] stays 5, overflow_o[0] not set.
//   5. Flush vs grant: ch2 holds 3 words, flush_i[2]=1 with gnt_i=1, sel=2
//      -> word delivered; next cycle cnt[2]=0, overflow_o[2]=0.
//   6. Reset/enable: mid-traffic rst=1 for 1 cycle -> all cnt 0, rr_ptr 0, req_o=0.
//      enable_i=0 with valid_i=3'b111 -> req_o=0, stall_o=3'b111, no pushes.
//      gnt_i=1 -> underflow_o=1.

Source files
------------

// File: rtl/path_pkg.sv
// Shared helpers for the multi-channel request/grant path: width
// calculations and the round-robin pointer advance.
package path_pkg;

  // Ceiling log2, never smaller than 1 so derived vectors stay legal.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Width of a channel index.
  function automatic int ch_w(input int nch);
    return clog2(nch);
  endfunction

  // Width of an occupancy count that must be able to hold the value depth.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Channel after sel, wrapping at nch.
  function automatic int rr_next(input int sel, input int nch);
    return (sel + 1 >= nch) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/path_fifo.sv
// Single-channel FIFO of arbitrary depth with synchronous flush. The head
// word is presented combinationally; a write lands at the head one cycle
// later at the earliest. Push is refused when full unless a pop happens in
// the same cycle, and a flush overrides both push and pop.
module path_fifo
  import path_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 5,
  localparam int PW   = clog2(FDEPTH),
  localparam int CNTW = cnt_w(FDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] head,
  output logic [CNTW-1:0]   cnt
);

  localparam logic [PW-1:0]   LAST_PTR = PW'(FDEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FDEPTH);

  logic [DWIDTH-1:0] mem_q [FDEPTH];
  logic [DWIDTH-1:0] mem_d [FDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              do_push, do_pop;

  // Qualify requests: never pop an empty FIFO, never grow past FDEPTH.
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != FULL_CNT) || do_pop);
  end

  // Pointer and occupancy update; flush wins over everything else.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage write; when full with a simultaneous pop the write reuses the
  // slot being read out this cycle.
  always_comb begin
    mem_d = mem_q;
    if (do_push && !flush) mem_d[wr_ptr_q] = din;
  end

  // Data storage carries no reset; only the control state below does.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/path_mc.sv
// Multi-channel request/grant path. Each channel has its own FIFO with an
// empty-FIFO bypass; a round-robin arbiter presents one word per cycle to a
// single consumer. Provides almost-full stall, sticky overflow on dropped
// pushes, and per-channel flush.
module path_mc
  import path_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 5,
  parameter int NCH    = 3,
  parameter int AFULL  = 4,
  localparam int CW    = ch_w(NCH),
  localparam int CNTW  = cnt_w(FDEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [NCH-1:0]        flush_i,
  input  logic [NCH-1:0]        valid_i,
  input  logic [NCH*DWIDTH-1:0] data_i,
  input  logic                  gnt_i,
  output logic                  req_o,
  output logic [CW-1:0]         ch_o,
  output logic [DWIDTH-1:0]     data_o,
  output logic [NCH-1:0]        stall_o,
  output logic [NCH-1:0]        overflow_o,
  output logic                  underflow_o
);

  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FDEPTH);
  localparam logic [CNTW-1:0] AFULL_CNT = CNTW'(AFULL);

  logic [CNTW-1:0]   cnt  [NCH];
  logic [DWIDTH-1:0] head [NCH];
  logic [NCH-1:0]    in_v, pend, pop, bypass, push, drop;
  logic [NCH-1:0]    overflow_q, overflow_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     sel;
  logic              req, fire;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    path_fifo #(
      .DWIDTH(DWIDTH),
      .FDEPTH(FDEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[c]),
      .pop  (pop[c]),
      .flush(flush_i[c]),
      .din  (data_i[c*DWIDTH +: DWIDTH]),
      .head (head[c]),
      .cnt  (cnt[c])
    );
  end

  // A channel is pending if it has stored words or an enabled input this cycle.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      in_v[c] = valid_i[c] && enable_i;
      pend[c] = (cnt[c] != '0) || in_v[c];
    end
  end

  // Round-robin pick: first pending channel scanning upward from rr_q.
  always_comb begin : arb
    int   idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pend[idx]) begin
        sel   = CW'(idx);
        found = 1'b1;
      end
    end
  end

  // Per-channel pop/bypass/push/drop decisions, stall and overflow next state.
  always_comb begin
    req  = |pend;
    fire = gnt_i && req;
    for (int c = 0; c < NCH; c++) begin
      pop[c]        = fire && (sel == CW'(c)) && (cnt[c] != '0);
      bypass[c]     = fire && (sel == CW'(c)) && (cnt[c] == '0);
      push[c]       = in_v[c] && !bypass[c] && !flush_i[c] &&
                      ((cnt[c] != FULL_CNT) || pop[c]);
      drop[c]       = in_v[c] && (cnt[c] == FULL_CNT) && !pop[c];
      overflow_d[c] = flush_i[c] ? 1'b0 : (overflow_q[c] || drop[c]);
      stall_o[c]    = !enable_i || (cnt[c] >= AFULL_CNT);
    end
  end

  // Output presentation: FIFO head when stored data exists, otherwise the
  // live input word; zeros when nothing is requested.
  always_comb begin
    req_o       = req;
    ch_o        = '0;
    data_o      = '0;
    underflow_o = gnt_i && !req;
    rr_d        = fire ? CW'(rr_next(int'(sel), NCH)) : rr_q;
    if (req) begin
      ch_o   = sel;
      data_o = (cnt[sel] != '0) ? head[sel] : data_i[int'(sel)*DWIDTH +: DWIDTH];
    end
  end

  // Arbiter pointer and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      overflow_q <= '0;
    end else begin
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_path_mc.sv
// Directed bench for path_mc with NCH=3, DWIDTH=8, FDEPTH=5, AFULL=4.
module tb_path_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [2:0]  flush_i;
  logic [2:0]  valid_i;
  logic [23:0] data_i;
  logic        gnt_i;
  logic        req_o;
  logic [1:0]  ch_o;
  logic [7:0]  data_o;
  logic [2:0]  stall_o;
  logic [2:0]  overflow_o;
  logic        underflow_o;

  int checks = 0;
  int errors = 0;

  path_mc #(
    .DWIDTH(8),
    .FDEPTH(5),
    .NCH   (3),
    .AFULL (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .gnt_i      (gnt_i),
    .req_o      (req_o),
    .ch_o       (ch_o),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable_i = 1'b0; flush_i = '0; valid_i = '0; data_i = '0; gnt_i = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_req",   32'(req_o), 0);
    chk("rst_ch",    32'(ch_o), 0);
    chk("rst_data",  32'(data_o), 0);
    chk("rst_ovf",   32'(overflow_o), 0);
    chk("rst_rr",    32'(dut.rr_q), 0);
    chk("rst_cnt0",  32'(dut.cnt[0]), 0);
    chk("rst_cnt2",  32'(dut.cnt[2]), 0);
    rst = 1'b0; enable_i = 1'b1; #1;
    chk("rst_stall", 32'(stall_o), 0);

    // 1. Zero-latency bypass on ch1
    valid_i = 3'b010; data_i = {8'h00, 8'hA5, 8'h00}; gnt_i = 1'b1; #1;
    chk("t1_req",  32'(req_o), 1);
    chk("t1_ch",   32'(ch_o), 1);
    chk("t1_data", 32'(data_o), 32'h A5);
    chk("t1_unf",  32'(underflow_o), 0);
    tick();
    chk("t1_cnt1", 32'(dut.cnt[1]), 0);
    chk("t1_rr",   32'(dut.rr_q), 2);
    valid_i = '0; gnt_i = 1'b0; data_i = '0;
    rst = 1'b1; tick(); rst = 1'b0;

    // 2. Round robin over two words per channel
    valid_i = 3'b111; data_i = {8'h30, 8'h20, 8'h10}; tick();
    data_i = {8'h31, 8'h21, 8'h11}; tick();
    valid_i = '0; data_i = '0;
    chk("t2_cnt1", 32'(dut.cnt[1]), 2);
    gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_data", 32'(data_o), 32'((i % 3 + 1) * 16 + i / 3));
      chk("t2_ch",   32'(ch_o), 32'(i % 3));
      tick();
    end
    #1;
    chk("t2_req_end", 32'(req_o), 0);
    gnt_i = 1'b0;

    // 3. Fill ch0 past capacity: stall, count limit, sticky overflow
    valid_i = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      data_i = {16'h0000, 8'(k)};
      tick();
      chk("t3_stall0", 32'(stall_o[0]), 32'(k >= 4));
      chk("t3_ovf0",   32'(overflow_o[0]), 32'(k == 6));
    end
    valid_i = '0; data_i = '0;
    chk("t3_cnt0", 32'(dut.cnt[0]), 5);
    gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_drain", 32'(data_o), 32'(i + 1));
      tick();
    end
    #1;
    chk("t3_req_end", 32'(req_o), 0);
    chk("t3_ovf_hold", 32'(overflow_o[0]), 1);
    gnt_i = 1'b0;
    flush_i = 3'b001; tick(); flush_i = '0;
    chk("t3_ovf_flush", 32'(overflow_o[0]), 0);

    // 4. Push and pop on a full channel in the same cycle
    valid_i = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      data_i = {16'h0000, 8'(k)};
      tick();
    end
    chk("t4_cnt_full", 32'(dut.cnt[0]), 5);
    data_i = {16'h0000, 8'h07}; gnt_i = 1'b1; #1;
    chk("t4_data", 32'(data_o), 1);
    chk("t4_ch",   32'(ch_o), 0);
    tick();
    valid_i = '0; gnt_i = 1'b0; data_i = '0;
    chk("t4_cnt0", 32'(dut.cnt[0]), 5);
    chk("t4_ovf0", 32'(overflow_o[0]), 0);
    gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_drain", 32'(data_o), (i < 4) ? 32'(i + 2) : 32'h7);
      tick();
    end
    gnt_i = 1'b0;

    // 5. Flush of ch2 while its head is granted; flush also discards a push
    valid_i = 3'b100;
    for (int k = 0; k < 3; k++) begin
      data_i = {8'(8'h40 + k), 16'h0000};
      tick();
    end
    valid_i = '0; data_i = '0;
    chk("t5_cnt2_pre", 32'(dut.cnt[2]), 3);
    flush_i = 3'b100; gnt_i = 1'b1; #1;
    chk("t5_data", 32'(data_o), 32'h40);
    chk("t5_ch",   32'(ch_o), 2);
    tick();
    flush_i = '0; gnt_i = 1'b0;
    chk("t5_cnt2", 32'(dut.cnt[2]), 0);
    chk("t5_ovf2", 32'(overflow_o[2]), 0);
    chk("t5_rr",   32'(dut.rr_q), 0);
    flush_i = 3'b100; valid_i = 3'b100; data_i = {8'h55, 16'h0000}; tick();
    flush_i = '0; valid_i = '0; data_i = '0;
    chk("t5_flush_push", 32'(dut.cnt[2]), 0);

    // 6. Reset mid-traffic, then global disable and underflow
    valid_i = 3'b111; data_i = {8'h03, 8'h02, 8'h01}; tick(); tick();
    valid_i = '0; gnt_i = 1'b1; tick(); gnt_i = 1'b0;
    chk("t6_rr_pre", 32'(dut.rr_q), 1);
    rst = 1'b1; valid_i = 3'b111; gnt_i = 1'b1; tick();
    rst = 1'b0; valid_i = '0; gnt_i = 1'b0; #1;
    chk("t6_cnt0", 32'(dut.cnt[0]), 0);
    chk("t6_cnt1", 32'(dut.cnt[1]), 0);
    chk("t6_cnt2", 32'(dut.cnt[2]), 0);
    chk("t6_rr",   32'(dut.rr_q), 0);
    chk("t6_req",  32'(req_o), 0);
    enable_i = 1'b0; valid_i = 3'b111; data_i = {8'h0C, 8'h0B, 8'h0A}; #1;
    chk("t6_dis_req",   32'(req_o), 0);
    chk("t6_dis_stall", 32'(stall_o), 32'h7);
    tick();
    chk("t6_dis_cnt1", 32'(dut.cnt[1]), 0);
    gnt_i = 1'b1; #1;
    chk("t6_unf", 32'(underflow_o), 1);
    tick();
    gnt_i = 1'b0; valid_i = '0; enable_i = 1'b1; #1;
    chk("t6_unf_nostate", 32'(dut.rr_q), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
